gf2m_inverter: RTL and testbench

//  Sequential GF(2^M) multiplicative inverter: z = a^-1 mod f(x).

---
 rtl/gf2m_inverter.sv | 185 ++++++++++++++++++
 tb/tb_gf2m_inverter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_inverter.sv
// ---------------------------------------------------------------------------
// gf2m_inverter
//   Sequential GF(2^M) multiplicative inverter, z = a^-1 mod f(x).
//   Uses the binary extended Euclidean algorithm and performs one reduction
//   step per clock. It shares its field with the interleaved multiplier:
//   f = x^163 + x^7 + x^6 + x^3 + 1 by default. It is used for affine
//   conversion and for division (a/b = a * b^-1).
//
//   Invariants held while running:
//     g1 * a == u (mod f)
//     g2 * a == v (mod f)
//   When u or v reaches 1, the matching g is the inverse.
//
// Ports
//   clk    in   1  clock, rising edge
//   rst    in   1  asynchronous, active-high reset
//   start  in   1  request; sampled only while idle
//   a      in   M  operand (already reduced); captured on the accepted start
//   z      out  M  inverse; valid from the done cycle until the next accept
//   busy   out  1  high while iterating
//   done   out  1  one-cycle completion pulse
//   err    out  1  set with done for a == 0 (or a tripped guard); z = 0
// ---------------------------------------------------------------------------
module gf2m_inverter #(
  parameter int          M    = 163,
  parameter logic [M-1:0] POLY = 163'hC9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  output logic [M-1:0] z,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int         DW       = $clog2(M + 1);
  // A reduced, nonzero operand always finishes well inside this many steps.
  localparam logic [9:0] ITER_MAX = 10'(4 * M);
  localparam logic [M:0] F_FULL   = {1'b1, POLY};
  localparam logic [M:0] ONE_W    = {{M{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [M:0]   u_q, u_d;
  logic [M:0]   v_q, v_d;
  logic [M-1:0] g1_q, g1_d;
  logic [M-1:0] g2_q, g2_d;
  logic [M-1:0] z_q, z_d;
  logic         err_q, err_d;
  logic [9:0]   iter_q, iter_d;

  logic [DW-1:0] deg_u, deg_v;

  // Index of the highest set bit. A later (higher) hit overrides an earlier one.
  function automatic logic [DW-1:0] degree(input logic [M:0] x);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i <= M; i++) begin
      if (x[i]) d = DW'(i);
    end
    return d;
  endfunction

  // Division by x modulo f. For an odd g, f is added first so that the low bit
  // becomes zero. Because g < x^M, the sum has bit M set, and that bit lands
  // in bit M-1 after the shift.
  function automatic logic [M-1:0] div_x(input logic [M-1:0] g);
    logic [M:0] t;
    t = g[0] ? (F_FULL ^ {1'b0, g}) : {1'b0, g};
    return t[M:1];
  endfunction

  always_comb begin
    deg_u = degree(u_q);
    deg_v = degree(v_q);
  end

  // State register (also holds the datapath)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      z_q     <= z_d;
      err_q   <= err_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    z_d     = z_q;
    err_d   = err_q;
    iter_d  = iter_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          u_d    = {1'b0, a};
          v_d    = F_FULL;
          g1_d   = {{(M-1){1'b0}}, 1'b1};
          g2_d   = '0;
          err_d  = 1'b0;
          iter_d = '0;
          if (a == '0) begin
            // Zero has no inverse: report it in the following cycle.
            z_d     = '0;
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        iter_d = iter_q + 10'd1;
        // z is loaded on the way into FIN, so it is already valid during done.
        if (u_q == ONE_W) begin
          z_d     = g1_q;
          state_d = FIN;
        end else if (v_q == ONE_W) begin
          z_d     = g2_q;
          state_d = FIN;
        end else if (iter_q == ITER_MAX) begin
          z_d     = '0;
          err_d   = 1'b1;
          state_d = FIN;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          g1_d = div_x(g1_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          g2_d = div_x(g2_q);
        end else if (deg_u > deg_v) begin
          u_d  = u_q ^ v_q;
          g1_d = g1_q ^ g2_q;
        end else begin
          v_d  = v_q ^ u_q;
          g2_d = g2_q ^ g1_q;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == FIN);
    z    = z_q;
    err  = err_q;
  end

endmodule

// File: tb/tb_gf2m_inverter.sv
module tb_gf2m_inverter;

  localparam int           M         = 163;
  localparam logic [M-1:0] POLY      = 163'hC9;
  localparam int           LAT_BOUND = 4 * M + 2;
  localparam int           LAT_LIMIT = 4 * M + 20;
  localparam int           N_RANDOM  = 64;

  logic         clk;
  logic         rst;
  logic         start;
  logic [M-1:0] a;
  logic [M-1:0] z;
  logic         busy;
  logic         done;
  logic         err;

  int n_checks;
  int n_fail;

  gf2m_inverter #(.M(M), .POLY(POLY)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .z     (z),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference field multiply: shift-and-add, reducing by f at every shift.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M:0] acc;
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      acc = {acc[M-1:0], 1'b0};
      if (acc[M]) acc = acc ^ {1'b1, POLY};
      if (y[i]) acc = acc ^ {1'b0, x};
    end
    return acc[M-1:0];
  endfunction

  function automatic logic [M-1:0] rand_elem();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (w[M-1:0] == '0) w[0] = 1'b1;
    return w[M-1:0];
  endfunction

  function automatic logic [M-1:0] x_inverse();
    logic [M-1:0] r;
    r = '0;
    r[162] = 1'b1;
    r[6]   = 1'b1;
    r[5]   = 1'b1;
    r[2]   = 1'b1;
    return r;
  endfunction

  // Stimulus only: issue a one-cycle start and count cycles until done.
  task automatic run_op(input logic [M-1:0] val, output int lat, output bit got);
    @(negedge clk);
    a     = val;
    start = 1'b1;
    lat   = 0;
    got   = 1'b0;
    while (!got && lat < LAT_LIMIT) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (z !== '0)   begin n_fail++; $display("FAIL reset_z: got %h want 0", z); end
    n_checks++; if (busy !== 0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 0)  begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: z=%h busy=%b done=%b err=%b", z, busy, done, err);
  endtask

  task automatic test_one();
    int lat;
    bit got;
    run_op(M'(1), lat, got);
    $display("op a=1 lat=%0d z=%h err=%b", lat, z, err);
    n_checks++; if (!got)          begin n_fail++; $display("FAIL one_done: no done within %0d cycles", LAT_LIMIT); end
    n_checks++; if (lat != 2)      begin n_fail++; $display("FAIL one_latency: got %0d want 2", lat); end
    n_checks++; if (z !== M'(1))   begin n_fail++; $display("FAIL one_z: got %h want 1", z); end
    n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL one_err: got %b want 0", err); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL one_done_pulse: got %b want 0", done); end
    n_checks++; if (z !== M'(1))   begin n_fail++; $display("FAIL one_z_hold: got %h want 1", z); end
  endtask

  task automatic test_x();
    int lat;
    bit got;
    run_op(M'(2), lat, got);
    $display("op a=2 lat=%0d z=%h err=%b", lat, z, err);
    n_checks++; if (!got)              begin n_fail++; $display("FAIL x_done: no done within %0d cycles", LAT_LIMIT); end
    n_checks++; if (z !== x_inverse()) begin n_fail++; $display("FAIL x_z: got %h want %h", z, x_inverse()); end
    n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL x_err: got %b want 0", err); end
  endtask

  task automatic test_zero();
    int lat;
    bit got;
    run_op('0, lat, got);
    $display("op a=0 lat=%0d z=%h err=%b", lat, z, err);
    n_checks++; if (!got)         begin n_fail++; $display("FAIL zero_done: no done within %0d cycles", LAT_LIMIT); end
    n_checks++; if (lat != 1)     begin n_fail++; $display("FAIL zero_latency: got %0d want 1", lat); end
    n_checks++; if (z !== '0)     begin n_fail++; $display("FAIL zero_z: got %h want 0", z); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL zero_err: got %b want 1", err); end
    // err must hold, then clear at the next accepted start.
    @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL zero_err_hold: got %b want 1", err); end
    a     = M'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL zero_err_clear: got %b want 0", err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_after_accept: got %b want 1", busy); end
    lat = 1;
    while (!done && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    $display("op a=1 after zero lat=%0d z=%h err=%b", lat, z, err);
    n_checks++; if (lat != 2)      begin n_fail++; $display("FAIL zero_then_one_latency: got %0d want 2", lat); end
    n_checks++; if (z !== M'(1))   begin n_fail++; $display("FAIL zero_then_one_z: got %h want 1", z); end
  endtask

  task automatic test_random();
    int lat;
    int max_lat;
    bit got;
    logic [M-1:0] val;
    max_lat = 0;
    for (int k = 0; k < N_RANDOM; k++) begin
      val = rand_elem();
      run_op(val, lat, got);
      if (lat > max_lat) max_lat = lat;
      $display("op rnd %0d lat=%0d a=%h z=%h", k, lat, val, z);
      n_checks++; if (!got)                  begin n_fail++; $display("FAIL rnd_done[%0d]: no done within %0d cycles", k, LAT_LIMIT); end
      n_checks++; if (lat > LAT_BOUND)       begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want <= %0d", k, lat, LAT_BOUND); end
      n_checks++; if (gf_mul(val, z) !== M'(1)) begin n_fail++; $display("FAIL rnd_product[%0d]: a*z=%h want 1", k, gf_mul(val, z)); end
      n_checks++; if (err !== 1'b0)          begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want 0", k, err); end
    end
    $display("random: max latency %0d (bound %0d)", max_lat, LAT_BOUND);
  endtask

  task automatic test_busy_ignore();
    logic [M-1:0] a1;
    logic [M-1:0] a2;
    int lat;
    int extra_done;
    a1 = rand_elem();
    a2 = rand_elem();
    @(negedge clk);
    a     = a1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Operand changes and a second request while running must both be ignored.
    a = a2;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 5;
    while (!done && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    $display("op busy_ignore lat=%0d a1=%h z=%h", lat, a1, z);
    n_checks++; if (done !== 1'b1)            begin n_fail++; $display("FAIL busy_done: no done within %0d cycles", LAT_LIMIT); end
    n_checks++; if (gf_mul(a1, z) !== M'(1))  begin n_fail++; $display("FAIL busy_product: a1*z=%h want 1", gf_mul(a1, z)); end
    extra_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    n_checks++; if (extra_done != 0) begin n_fail++; $display("FAIL busy_no_queue: got %0d active cycles want 0", extra_done); end
  endtask

  task automatic test_start_held();
    int lat;
    a     = M'(1);
    start = 1'b1;
    lat   = 0;
    @(negedge clk);
    while (!done && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL held_first_done: no done within %0d cycles", LAT_LIMIT); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL held_idle_gap: busy=%b done=%b want 0 0", busy, done); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_restart: busy=%b want 1", busy); end
    @(negedge clk);
    start = 1'b0;
    $display("op start_held second done=%b z=%h", done, z);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL held_second_done: got %b want 1", done); end
    n_checks++; if (z !== M'(1))   begin n_fail++; $display("FAIL held_z: got %h want 1", z); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int done_seen;
    bit got;
    @(negedge clk);
    a     = rand_elem();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_running: busy=%b want 1", busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (z !== '0)      begin n_fail++; $display("FAIL rstmid_z: got %h want 0", z); end
    n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL rstmid_err: got %b want 0", err); end
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_seen); end
    run_op(M'(2), lat, got);
    $display("op after reset a=2 lat=%0d z=%h", lat, z);
    n_checks++; if (!got)              begin n_fail++; $display("FAIL rstmid_after_done: no done within %0d cycles", LAT_LIMIT); end
    n_checks++; if (z !== x_inverse()) begin n_fail++; $display("FAIL rstmid_after_z: got %h want %h", z, x_inverse()); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_one();
    test_x();
    test_zero();
    test_random();
    test_busy_ignore();
    test_start_held();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
